// File: rtl/sms_ahb_sram_ctrl_if.sv
// AHB-lite signal bundle between the main matrix and one sms SRAM port.
interface sms_ahb_sram_ctrl_if;
    logic        ahb_sms_hsel;
    logic [31:0] ahb_sms_haddr;
    logic [1:0]  ahb_sms_htrans;
    logic [2:0]  ahb_sms_hsize;
    logic        ahb_sms_hwrite;
    logic [31:0] ahb_sms_hwdata;
    logic [3:0]  ahb_sms_hprot;
    logic [31:0] sms_ahb_hrdata;
    logic        sms_ahb_hready;
    logic [1:0]  sms_ahb_hresp;

    modport master (
        output ahb_sms_hsel, ahb_sms_haddr, ahb_sms_htrans, ahb_sms_hsize,
               ahb_sms_hwrite, ahb_sms_hwdata, ahb_sms_hprot,
        input  sms_ahb_hrdata, sms_ahb_hready, sms_ahb_hresp
    );

    modport slave (
        input  ahb_sms_hsel, ahb_sms_haddr, ahb_sms_htrans, ahb_sms_hsize,
               ahb_sms_hwrite, ahb_sms_hwdata, ahb_sms_hprot,
        output sms_ahb_hrdata, sms_ahb_hready, sms_ahb_hresp
    );
endinterface

// File: rtl/sms_ahb_sram_ctrl.sv
// AHB-lite slave to single-port SRAM bridge with a one-entry write buffer and read forwarding.
// Optional: define SMS_WR_PROT_EN to reject user-mode (hprot[1]=0) writes with an ERROR response.
module sms_ahb_sram_ctrl #(
    parameter int unsigned MEM_AW  = 14,
    parameter int unsigned RD_WAIT = 0
) (
    input  logic                pmu_sms_hclk,
    input  logic                pmu_sms_hrst,
    sms_ahb_sram_ctrl_if.slave  ahb,
    input  logic                sms_big_endian_b,
    output logic                sms_idle,
    output logic                sram_ce,
    output logic                sram_we,
    output logic [MEM_AW-1:0]   sram_addr,
    output logic [31:0]         sram_wdata,
    output logic [3:0]          sram_wbe,
    input  logic [31:0]         sram_rdata
);
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_WSTALL = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;

    localparam logic [CW-1:0] RD_WAIT_C = CW'(RD_WAIT);

    logic [2:0]        state_q, state_n;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_n;
    logic              hready_q, hready_n;
    logic [1:0]        hresp_q, hresp_n;
    logic              idle_q, idle_n;
    logic [DW-1:0]     hrdata_q, hrdata_c;
    logic              wb_valid_q, wb_valid_n;
    logic [MEM_AW-1:0] wb_addr_q, wb_addr_n;
    logic [DW-1:0]     wb_data_q, wb_data_n;
    logic [BW-1:0]     wb_be_q, wb_be_n;
    logic [MEM_AW-1:0] pend_addr_q, pend_addr_n;
    logic [BW-1:0]     pend_be_q, pend_be_n;
    logic [MEM_AW-1:0] rd_addr_q, rd_addr_n;
    logic [BW-1:0]     fwd_be_q, fwd_be_n;
    logic [DW-1:0]     fwd_data_q, fwd_data_n;

    logic [MEM_AW-1:0] word_addr_c;
    logic [1:0]        lane_c;
    logic [BW-1:0]     be_c;
    logic              prot_err_c, illegal_c;
    logic              rd_req_c, stall_c, load_c, restrobe_c;
    logic              hready_c, addr_phase_c, rd_strobe_c, drain_c, rd_done_c;
    logic              unused_c;

    assign unused_c = ^{ahb.ahb_sms_haddr[31:MEM_AW+2], ahb.ahb_sms_htrans[0], ahb.ahb_sms_hprot};

    // Address-phase decode: word address, byte lanes and legality.
    always_comb begin
        word_addr_c = ahb.ahb_sms_haddr[MEM_AW+1:2];
        lane_c      = sms_big_endian_b ? ahb.ahb_sms_haddr[1:0] : ~ahb.ahb_sms_haddr[1:0];
        case (ahb.ahb_sms_hsize)
            3'd0:    be_c = BW'(4'b0001 << lane_c);
            3'd1:    be_c = (ahb.ahb_sms_haddr[1] ^ ~sms_big_endian_b) ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
`ifdef SMS_WR_PROT_EN
        prot_err_c = ahb.ahb_sms_hwrite & ~ahb.ahb_sms_hprot[1];
`else
        prot_err_c = 1'b0;
`endif
        illegal_c = (ahb.ahb_sms_hsize > 3'd2)
                  | ((ahb.ahb_sms_hsize == 3'd1) & ahb.ahb_sms_haddr[0])
                  | ((ahb.ahb_sms_hsize == 3'd2) & (ahb.ahb_sms_haddr[1:0] != 2'b00))
                  | prot_err_c;
        rd_req_c = ahb.ahb_sms_hsel & ahb.ahb_sms_htrans[1] & ~ahb.ahb_sms_hwrite;
    end

    // Next-state, buffer and forwarding logic.
    always_comb begin
        state_n     = state_q;
        rd_cnt_n    = rd_cnt_q;
        wb_valid_n  = wb_valid_q;
        wb_addr_n   = wb_addr_q;
        wb_data_n   = wb_data_q;
        wb_be_n     = wb_be_q;
        pend_addr_n = pend_addr_q;
        pend_be_n   = pend_be_q;
        rd_addr_n   = rd_addr_q;
        fwd_be_n    = fwd_be_q;
        fwd_data_n  = fwd_data_q;
        stall_c     = 1'b0;
        load_c      = 1'b0;
        restrobe_c  = 1'b0;

        case (state_q)
            S_WR: begin
                // A full buffer cannot both drain and accept while a read owns the SRAM.
                stall_c = wb_valid_q & rd_req_c;
                load_c  = ~stall_c;
            end
            S_WSTALL: load_c = 1'b1;
            S_RD:     restrobe_c = (rd_cnt_q == CW'(1));
            default:  ;
        endcase

        hready_c     = hready_q & ~stall_c;
        addr_phase_c = hready_c & ahb.ahb_sms_hsel & ahb.ahb_sms_htrans[1];
        rd_strobe_c  = (addr_phase_c & ~ahb.ahb_sms_hwrite & ~illegal_c) | restrobe_c;
        drain_c      = wb_valid_q & ~rd_strobe_c;
        rd_done_c    = (state_q == S_RD) & (rd_cnt_q == '0);

        if (drain_c) begin
            wb_valid_n = 1'b0;
        end
        if (load_c) begin
            wb_valid_n = 1'b1;
            wb_addr_n  = pend_addr_q;
            wb_data_n  = ahb.ahb_sms_hwdata;
            wb_be_n    = pend_be_q;
        end

        if (hready_c) begin
            if (!addr_phase_c) begin
                state_n = S_IDLE;
            end else if (illegal_c) begin
                state_n = S_ERR1;
            end else if (ahb.ahb_sms_hwrite) begin
                state_n     = S_WR;
                pend_addr_n = word_addr_c;
                pend_be_n   = be_c;
            end else begin
                state_n    = S_RD;
                rd_cnt_n   = RD_WAIT_C;
                rd_addr_n  = word_addr_c;
                fwd_data_n = wb_data_n;
                fwd_be_n   = (wb_valid_n && (wb_addr_n == word_addr_c)) ? wb_be_n : '0;
            end
        end else begin
            case (state_q)
                S_RD:    rd_cnt_n = rd_cnt_q - CW'(1);
                S_WR:    state_n  = S_WSTALL;
                S_ERR1:  state_n  = S_ERR2;
                default: state_n  = S_IDLE;
            endcase
        end

        hready_n = ~(((state_n == S_RD) && (rd_cnt_n != '0)) || (state_n == S_ERR1));
        hresp_n  = ((state_n == S_ERR1) || (state_n == S_ERR2)) ? 2'b01 : 2'b00;
        idle_n   = (state_n == S_IDLE) & ~wb_valid_n;
    end

    // Read data merge: buffered bytes override stale SRAM bytes.
    always_comb begin
        hrdata_c = hrdata_q;
        if (rd_done_c) begin
            for (int i = 0; i < BW; i++) begin
                hrdata_c[8*i +: 8] = fwd_be_q[i] ? fwd_data_q[8*i +: 8] : sram_rdata[8*i +: 8];
            end
        end
    end

    // SRAM port; strobes are suppressed while reset is asserted so a pending write is dropped.
    always_comb begin
        sram_ce    = ~pmu_sms_hrst & (rd_strobe_c | drain_c);
        sram_we    = ~pmu_sms_hrst & drain_c;
        sram_wbe   = (~pmu_sms_hrst & drain_c) ? wb_be_q : '0;
        sram_wdata = wb_data_q;
        if (restrobe_c) begin
            sram_addr = rd_addr_q;
        end else if (rd_strobe_c) begin
            sram_addr = word_addr_c;
        end else begin
            sram_addr = wb_addr_q;
        end
    end

    assign ahb.sms_ahb_hready = hready_c;
    assign ahb.sms_ahb_hresp  = hresp_q;
    assign ahb.sms_ahb_hrdata = hrdata_c;
    assign sms_idle           = idle_q;

    // State and datapath registers.
    always_ff @(posedge pmu_sms_hclk) begin
        if (pmu_sms_hrst) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            hready_q    <= 1'b1;
            hresp_q     <= 2'b00;
            idle_q      <= 1'b1;
            hrdata_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_be_q     <= '0;
            pend_addr_q <= '0;
            pend_be_q   <= '0;
            rd_addr_q   <= '0;
            fwd_be_q    <= '0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_n;
            rd_cnt_q    <= rd_cnt_n;
            hready_q    <= hready_n;
            hresp_q     <= hresp_n;
            idle_q      <= idle_n;
            hrdata_q    <= hrdata_c;
            wb_valid_q  <= wb_valid_n;
            wb_addr_q   <= wb_addr_n;
            wb_data_q   <= wb_data_n;
            wb_be_q     <= wb_be_n;
            pend_addr_q <= pend_addr_n;
            pend_be_q   <= pend_be_n;
            rd_addr_q   <= rd_addr_n;
            fwd_be_q    <= fwd_be_n;
            fwd_data_q  <= fwd_data_n;
        end
    end
endmodule

// File: tb/tb_sms_ahb_sram_ctrl.sv
// Directed bench: a zero-wait instance and an RD_WAIT=2 instance share one AHB stimulus stream.
module tb_sms_ahb_sram_ctrl;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, big_b, mem_clr;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;

    sms_ahb_sram_ctrl_if bus0 ();
    sms_ahb_sram_ctrl_if bus2 ();

    assign bus0.ahb_sms_hsel   = hsel;    assign bus2.ahb_sms_hsel   = hsel;
    assign bus0.ahb_sms_haddr  = haddr;   assign bus2.ahb_sms_haddr  = haddr;
    assign bus0.ahb_sms_htrans = htrans;  assign bus2.ahb_sms_htrans = htrans;
    assign bus0.ahb_sms_hsize  = hsize;   assign bus2.ahb_sms_hsize  = hsize;
    assign bus0.ahb_sms_hwrite = hwrite;  assign bus2.ahb_sms_hwrite = hwrite;
    assign bus0.ahb_sms_hwdata = hwdata;  assign bus2.ahb_sms_hwdata = hwdata;
    assign bus0.ahb_sms_hprot  = hprot;   assign bus2.ahb_sms_hprot  = hprot;

    logic          idle0, ce0, we0, idle2, ce2, we2;
    logic [AW-1:0] addr0, addr2;
    logic [31:0]   wdata0, rdata0, wdata2, rdata2;
    logic [3:0]    wbe0, wbe2;
    logic [31:0]   mem0 [1<<AW];
    logic [31:0]   mem2 [1<<AW];

    sms_ahb_sram_ctrl #(.MEM_AW(AW), .RD_WAIT(0)) dut0 (
        .pmu_sms_hclk(clk), .pmu_sms_hrst(rst), .ahb(bus0), .sms_big_endian_b(big_b),
        .sms_idle(idle0), .sram_ce(ce0), .sram_we(we0), .sram_addr(addr0),
        .sram_wdata(wdata0), .sram_wbe(wbe0), .sram_rdata(rdata0)
    );

    sms_ahb_sram_ctrl #(.MEM_AW(AW), .RD_WAIT(2)) dut2 (
        .pmu_sms_hclk(clk), .pmu_sms_hrst(rst), .ahb(bus2), .sms_big_endian_b(big_b),
        .sms_idle(idle2), .sram_ce(ce2), .sram_we(we2), .sram_addr(addr2),
        .sram_wdata(wdata2), .sram_wbe(wbe2), .sram_rdata(rdata2)
    );

    // Synchronous single-port SRAM models with byte-write enables.
    always_ff @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem0[i] <= '0;
                mem2[i] <= '0;
            end
            rdata0 <= '0;
            rdata2 <= '0;
        end else begin
            if (ce0) begin
                if (we0) begin
                    for (int b = 0; b < 4; b++) if (wbe0[b]) mem0[addr0][8*b +: 8] <= wdata0[8*b +: 8];
                end else begin
                    rdata0 <= mem0[addr0];
                end
            end
            if (ce2) begin
                if (we2) begin
                    for (int b = 0; b < 4; b++) if (wbe2[b]) mem2[addr2][8*b +: 8] <= wdata2[8*b +: 8];
                end else begin
                    rdata2 <= mem2[addr2];
                end
            end
        end
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'd2;
    endtask

    task automatic bus_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1; big_b = 1'b1; hprot = 4'b0011; hwdata = '0;
        bus_idle();
        tick(); tick();
        rst = 1'b0; mem_clr = 1'b0;
        // Reset state
        #2;
        chk("rst_hready", bus0.sms_ahb_hready, 1);
        chk("rst_hresp", bus0.sms_ahb_hresp, 0);
        chk("rst_hrdata", bus0.sms_ahb_hrdata, 0);
        chk("rst_idle", idle0, 1);
        chk("rst_ce", ce0, 0);
        chk("rst_hready2", bus2.sms_ahb_hready, 1);
        chk("rst_hresp2", bus2.sms_ahb_hresp, 0);
        chk("rst_idle2", idle2, 1);
        // Word write 0x10 then idle: zero-wait, drain next cycle
        tick(); bus_addr(1'b1, 32'h10, 3'd2); #2;
        chk("w1_addr_hready", bus0.sms_ahb_hready, 1);
        chk("w1_addr_ce", ce0, 0);
        tick(); bus_idle(); hwdata = 32'hDEADBEEF; #2;
        chk("w1_data_hready", bus0.sms_ahb_hready, 1);
        chk("w1_data_ce", ce0, 0);
        chk("w1_data_idle", idle0, 0);
        tick(); #2;
        chk("w1_drain_ce", ce0, 1);
        chk("w1_drain_we", we0, 1);
        chk("w1_drain_addr", addr0, 32'h4);
        chk("w1_drain_wbe", wbe0, 4'hF);
        chk("w1_drain_wdata", wdata0, 32'hDEADBEEF);
        chk("w1_drain_idle", idle0, 0);
        tick(); #2;
        chk("w1_after_idle", idle0, 1);
        chk("w1_after_ce", ce0, 0);
        // Write 0x20 then immediate read of 0x20: forwarded data
        tick(); bus_addr(1'b1, 32'h20, 3'd2);
        tick(); hwdata = 32'h11223344; bus_addr(1'b0, 32'h20, 3'd2); #2;
        chk("fwd_addr_hready", bus0.sms_ahb_hready, 1);
        chk("fwd_addr_ce", ce0, 1);
        chk("fwd_addr_we", we0, 0);
        chk("fwd_addr_addr", addr0, 32'h8);
        tick(); bus_idle(); #2;
        chk("fwd_data_hready", bus0.sms_ahb_hready, 1);
        chk("fwd_data_hrdata", bus0.sms_ahb_hrdata, 32'h11223344);
        chk("fwd_drain_we", we0, 1);
        chk("fwd_drain_addr", addr0, 32'h8);
        tick(); #2;
        chk("fwd_hold_hrdata", bus0.sms_ahb_hrdata, 32'h11223344);
        // Byte write 0x21 in LE then BE
        tick(); bus_addr(1'b1, 32'h21, 3'd0);
        tick(); bus_idle(); hwdata = 32'h0000AB00;
        tick(); #2;
        chk("le_byte_wbe", wbe0, 4'b0010);
        chk("le_byte_addr", addr0, 32'h8);
        tick(); big_b = 1'b0; bus_addr(1'b1, 32'h21, 3'd0);
        tick(); bus_idle();
        tick(); #2;
        chk("be_byte_wbe", wbe0, 4'b0100);
        big_b = 1'b1;
        tick(); bus_addr(1'b0, 32'h20, 3'd2);
        tick(); bus_idle(); #2;
        chk("byte_merge_hrdata", bus0.sms_ahb_hrdata, 32'h1100AB44);
        // Misaligned word read: two-cycle ERROR, then a legal read
        tick(); bus_addr(1'b0, 32'h02, 3'd2); #2;
        chk("err_addr_ce", ce0, 0);
        chk("err_addr_hready", bus0.sms_ahb_hready, 1);
        tick(); bus_idle(); #2;
        chk("err1_hready", bus0.sms_ahb_hready, 0);
        chk("err1_hresp", bus0.sms_ahb_hresp, 2'b01);
        chk("err1_ce", ce0, 0);
        tick(); bus_addr(1'b0, 32'h04, 3'd2); #2;
        chk("err2_hready", bus0.sms_ahb_hready, 1);
        chk("err2_hresp", bus0.sms_ahb_hresp, 2'b01);
        chk("err2_sample_ce", ce0, 1);
        chk("err2_sample_addr", addr0, 32'h1);
        tick(); bus_idle(); #2;
        chk("post_err_hresp", bus0.sms_ahb_hresp, 0);
        chk("post_err_hready", bus0.sms_ahb_hready, 1);
        chk("post_err_hrdata", bus0.sms_ahb_hrdata, 0);
        // Write, write, read back-to-back: one stall cycle
        tick(); bus_addr(1'b1, 32'h30, 3'd2);
        tick(); hwdata = 32'hA0A0A0A0; bus_addr(1'b1, 32'h34, 3'd2); #2;
        chk("ww_w2addr_hready", bus0.sms_ahb_hready, 1);
        tick(); hwdata = 32'hB0B0B0B0; bus_addr(1'b0, 32'h30, 3'd2); #2;
        chk("wstall_hready", bus0.sms_ahb_hready, 0);
        chk("wstall_we", we0, 1);
        chk("wstall_addr", addr0, 32'hC);
        chk("wstall_wdata", wdata0, 32'hA0A0A0A0);
        tick(); #2;
        chk("wstall_done_hready", bus0.sms_ahb_hready, 1);
        chk("wstall_rd_ce", ce0, 1);
        chk("wstall_rd_we", we0, 0);
        chk("wstall_rd_addr", addr0, 32'hC);
        tick(); bus_idle(); #2;
        chk("wwr_hrdata", bus0.sms_ahb_hrdata, 32'hA0A0A0A0);
        chk("wwr_hready", bus0.sms_ahb_hready, 1);
        chk("wwr_drain_we", we0, 1);
        chk("wwr_drain_addr", addr0, 32'hD);
        tick(); bus_addr(1'b0, 32'h34, 3'd2);
        tick(); bus_idle(); #2;
        chk("w2_readback", bus0.sms_ahb_hrdata, 32'hB0B0B0B0);
        // Reset with a buffered write pending
        tick(); bus_addr(1'b1, 32'h50, 3'd2);
        tick(); bus_idle(); hwdata = 32'h55AA55AA;
        tick(); rst = 1'b1; #2;
        chk("rst_pend_ce", ce0, 0);
        tick(); rst = 1'b0; #2;
        chk("rst2_hready", bus0.sms_ahb_hready, 1);
        chk("rst2_hresp", bus0.sms_ahb_hresp, 0);
        chk("rst2_hrdata", bus0.sms_ahb_hrdata, 0);
        chk("rst2_idle", idle0, 1);
        chk("rst2_ce", ce0, 0);
        chk("rst2_wbe", wbe0, 0);
        tick(); bus_addr(1'b0, 32'h50, 3'd2);
        tick(); bus_idle(); #2;
        chk("rst_dropped_hrdata", bus0.sms_ahb_hrdata, 0);
        chk("rst_dropped_mem", mem0[8'h14], 0);
        tick(); tick();
        // RD_WAIT=2 instance: write 0x40 then read it back
        tick(); bus_addr(1'b1, 32'h40, 3'd2);
        tick(); bus_idle(); hwdata = 32'hCAFEF00D;
        tick(); #2;
        chk("rw2_drain_ce", ce2, 1);
        chk("rw2_drain_we", we2, 1);
        chk("rw2_drain_wbe", wbe2, 4'hF);
        chk("rw2_drain_wdata", wdata2, 32'hCAFEF00D);
        tick(); bus_addr(1'b0, 32'h40, 3'd2); #2;
        chk("rw2_addr_hready", bus2.sms_ahb_hready, 1);
        chk("rw2_addr_ce", ce2, 1);
        chk("rw2_addr_we", we2, 0);
        tick(); bus_idle(); #2;
        chk("rw2_wait1_hready", bus2.sms_ahb_hready, 0);
        chk("rw2_wait1_ce", ce2, 0);
        tick(); #2;
        chk("rw2_wait2_hready", bus2.sms_ahb_hready, 0);
        chk("rw2_restrobe_ce", ce2, 1);
        chk("rw2_restrobe_we", we2, 0);
        chk("rw2_restrobe_addr", addr2, 32'h10);
        tick(); #2;
        chk("rw2_done_hready", bus2.sms_ahb_hready, 1);
        chk("rw2_done_hrdata", bus2.sms_ahb_hrdata, 32'hCAFEF00D);
        chk("rw2_done_hresp", bus2.sms_ahb_hresp, 0);
        chk("rw2_idle", idle2, 0);
        tick(); #2;
        chk("rw2_hold_hrdata", bus2.sms_ahb_hrdata, 32'hCAFEF00D);
        chk("rw2_idle_after", idle2, 1);
        // Final SRAM contents seen by the zero-wait instance
        chk("mem_w1", mem0[8'h04], 32'hDEADBEEF);
        chk("mem_ww1", mem0[8'h0C], 32'hA0A0A0A0);
        chk("mem_ww2", mem0[8'h0D], 32'hB0B0B0B0);
        chk("mem_bytes", mem0[8'h08], 32'h1100AB44);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sms_ahb_sram_ctrl.md
Name: sms_ahb_sram_ctrl

Overview:
- One AHB-lite slave port of the on-chip memory subsystem. Four instances sit beneath the sms top level, one per main-matrix slave port (s2/s3/s4 data, s0 instruction).
- Converts AHB-lite transfers into accesses on a single-port synchronous SRAM macro.
- Writes complete with zero wait states through a one-entry write buffer; reads return with zero wait states when RD_WAIT=0.
- Read data is forwarded from the buffer when the buffered write has not yet reached the SRAM.

Parameters:
MEM_AW, 14, SRAM word-address width (2^MEM_AW x 32-bit words; haddr[MEM_AW+1:2] used)
RD_WAIT, 0, extra read wait states, 0..3

Ports:
pmu_sms_hclk  in  1  clock
pmu_sms_hrst  in  1  synchronous reset, active-high
ahb_sms_hsel  in  1  slave select (matrix asserts only in valid address phases)
ahb_sms_haddr  in  32  address
ahb_sms_htrans  in  2  transfer type
ahb_sms_hsize  in  3  transfer size
ahb_sms_hwrite  in  1  1=write
ahb_sms_hwdata  in  32  write data (data phase)
ahb_sms_hprot  in  4  protection
sms_big_endian_b  in  1  1=little-endian, 0=BE-32 byte-lane mapping
sms_ahb_hrdata  out  32  read data
sms_ahb_hready  out  1  transfer done / address sampled
sms_ahb_hresp  out  2  00 OKAY, 01 ERROR
sms_idle  out  1  no data phase, no wait state, write buffer empty
sram_ce  out  1  SRAM access strobe, active-high
sram_we  out  1  1=write
sram_addr  out  MEM_AW  word address
sram_wdata  out  32  write data
sram_wbe  out  4  byte-write enables
sram_rdata  in  32  read data, valid one cycle after a read strobe

Behaviour:
- Reset values (sync, synchronous priority over all else): hready=1, hresp=00, hrdata=0, sram_ce=0, sram_we=0, sram_wbe=0, write buffer invalid (wb_valid=0), FSM=IDLE, sms_idle=1. A buffered write pending at reset is discarded.
- Address sampling: the address phase is sampled only when sms_ahb_hready=1, hsel=1 and htrans[1]=1. IDLE/BUSY transfers get a zero-wait OKAY.
- Legality check:
  - hsize>2 → ERROR.
  - hsize=1 with haddr[0]=1 → ERROR.
  - hsize=2 with haddr[1:0]!=0 → ERROR.
- Byte lanes:
  - LE: byte lane=haddr[1:0]; half lanes={haddr[1],0}+1:+0; word=4'hF.
  - BE (big_endian_b=0): byte lane=3-haddr[1:0]; half at haddr[1]=0 → lanes 3:2.
  - Data is never swapped.
- FSM states: IDLE, RD (read data phase, counts RD_WAIT), WR (write data phase), WSTALL, ERR1, ERR2.
- Read:
  - In the address-phase cycle N: sram_ce=1, sram_we=0, sram_addr=haddr[MEM_AW+1:2].
  - hrdata is registered from sram_rdata; hready=1 at cycle N+1+RD_WAIT, with hready=0 in the intervening cycles.
  - The SRAM is re-strobed on the final wait cycle when RD_WAIT>0.
- Write:
  - Address phase latches word address and byte enables. Data phase: hready=1 (zero-wait) unless it stalls; at its completion hwdata and the enables load the buffer.
  - Drain: in any cycle with wb_valid=1 and no read strobe, the controller issues sram_ce=1, we=1, addr/wdata/wbe from the buffer, and wb_valid clears at the clock edge.
  - Read strobes have priority over drain.
- Buffer-full stall: if a write data phase arrives while wb_valid=1 and a read address phase is presented in the same cycle → WSTALL.
  - WSTALL drives hready=0 for one cycle and drains the old entry.
  - The next cycle completes the write and the pending read address phase is then resampled.
  - A non-read address phase drains and reloads the buffer in the same cycle without stalling.
- Forwarding: at the end of a read's address-phase cycle, the controller compares the next-state buffer (including a write loading that cycle) with the read word address.
  - On a match, it captures fwd_be/fwd_data.
  - hrdata = per-byte fwd_be ? fwd_data : sram_rdata.
- Error:
  - ERR1: hready=0, hresp=01. ERR2: hready=1, hresp=01.
  - No SRAM access; the buffer is untouched.
  - An address phase presented during ERR2 is sampled normally.
- hresp=00 in all other states. hrdata holds its last value outside read completion.
- sms_idle=1 iff FSM=IDLE and wb_valid=0.

Optional Feature:
SMS_WR_PROT_EN:
- Defined: a write address phase with hprot[1]=0 (user) takes the two-cycle ERROR response; the buffer and SRAM are not written. Reads are unaffected.
- Undefined: hprot is ignored entirely.

Test Plan:
- Reset then word write 0x0000_0010 ← 0xDEADBEEF, followed by IDLE → no stall; drain on next cycle with sram_we=1, addr=4, wbe=F; sms_idle returns to 1 afterwards.
- Write 0x20 ← 0x11223344, then an immediate word read of 0x20 (SRAM held 0) → forwarded hrdata=0x11223344 with zero wait; drain occurs after the read.
- Byte write 0x21 ← 0x0000AB00 with LE, then the same transfer with BE → wbe=0010 and 0100 respectively.
- Word read at 0x02 → hresp=01 with hready 0 then 1, no sram_ce; a following legal read at 0x04 returns OKAY.
- RD_WAIT=2, read 0x40 → hready low two cycles, data on third cycle; write, write, read back-to-back → exactly one WSTALL cycle and both writes land in SRAM.
- Assert pmu_sms_hrst while wb_valid=1 → no SRAM write occurs; all outputs at reset values the next cycle.
